// File: rtl/f_stage_pkg.sv
// Shared types and sizing constants for the f-word block accumulator stage.
package f_stage_pkg;

   // Width of the producer's registered result word f.
   localparam int F_W = 12;

   // Default number of samples grouped into one block.
   localparam int F_N = 4;

   // Default sum width; wide enough for F_N full-scale F_W-bit samples.
   localparam int F_SUM_W = 16;

   // Counter width needed to count 0..n-1 (n is at least 2, so never 0).
   function automatic int f_cnt_w(input int n);
      return $clog2(n);
   endfunction

   // Default counter width for the default block size.
   localparam int F_CNT_W = f_cnt_w(F_N);

   // Block accumulator states: accumulating samples, or holding a finished result.
   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/f_block_cnt.sv
// Modulo-N sample counter with synchronous active-low clear and last-sample flag.
module f_block_cnt
   import f_stage_pkg::*;
#(
   parameter int N     = F_N,
   parameter int CNT_W = F_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   logic [CNT_W-1:0] cnt_reg;

   // Completion is flagged on the accepting edge, so cnt never holds the value N.
   assign last = inc & (cnt_reg == CNT_LAST);
   assign cnt  = cnt_reg;

   // Count accepted samples, wrapping to zero on the last sample of a block.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (inc) begin
         if (last) begin
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/f_block_accum.sv
// Groups every N accepted f words into a block and emits its sum and maximum.
module f_block_accum
   import f_stage_pkg::*;
#(
   parameter int W     = F_W,
   parameter int N     = F_N,
   parameter int SUM_W = F_SUM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic [W-1:0]     out_max,
   output logic             out_valid,
   input  logic             out_ready
);

   // SUM_W must be at least W + clog2(N); the running sum then cannot overflow.
   localparam int CNT_W = f_cnt_w(N);

   state_t           state_reg;
   logic [SUM_W-1:0] acc_reg;
   logic [W-1:0]     max_reg;
   logic [SUM_W-1:0] out_sum_reg;
   logic [W-1:0]     out_max_reg;
   logic             out_valid_reg;

   logic             accept;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic [SUM_W-1:0] acc_next;
   logic [W-1:0]     max_next;

   // Ready depends only on state, enable and reset, never on in_valid.
   assign in_ready = (state_reg == ACC) & en & rst;
   assign accept   = in_valid & in_ready;

   assign out_sum   = out_sum_reg;
   assign out_max   = out_max_reg;
   assign out_valid = out_valid_reg;

   f_block_cnt #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (accept),
      .cnt  (cnt),
      .last (last)
   );

   // Running sum and maximum including the sample offered this cycle; the
   // first sample of a block loads the maximum directly.
   always_comb begin
      acc_next = acc_reg + {{(SUM_W - W){1'b0}}, in_data};
      max_next = max_reg;
      if ((cnt == '0) || (in_data > max_reg)) begin
         max_next = in_data;
      end
   end

   // Block state machine: accumulate N samples, then hold the result until taken.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ACC;
         acc_reg       <= '0;
         max_reg       <= '0;
         out_sum_reg   <= '0;
         out_max_reg   <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ACC: begin
               if (accept) begin
                  if (last) begin
                     out_sum_reg   <= acc_next;
                     out_max_reg   <= max_next;
                     out_valid_reg <= 1'b1;
                     state_reg     <= HOLD;
                     acc_reg       <= '0;
                     max_reg       <= '0;
                  end else begin
                     acc_reg <= acc_next;
                     max_reg <= max_next;
                  end
               end
            end
            HOLD: begin
               if (out_valid_reg && out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= ACC;
               end
            end
            default: begin
               state_reg     <= ACC;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_f_block_accum.sv
// Directed self-checking bench for f_block_accum (W=12, N=4, SUM_W=16).
module tb_f_block_accum;

   logic        clk;
   logic        rst;
   logic        en;
   logic [11:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_sum;
   logic [11:0] out_max;
   logic        out_valid;
   logic        out_ready;

   int checks;
   int failures;

   f_block_accum #(
      .W     (12),
      .N     (4),
      .SUM_W (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sum   (out_sum),
      .out_max   (out_max),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge and settle past it before looking at outputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample for one cycle.
   task automatic push(input logic [11:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick(); tick();
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 16'd0 || out_max !== 12'd0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%0b sum=%0d max=%0d, want 0/0/0", out_valid, out_sum, out_max);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_in_ready_low: got %0b want 0", in_ready);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready_after: got %0b want 1", in_ready);
      end
      $display("reset: valid=%0b in_ready=%0b", out_valid, in_ready);
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      push(12'd1); push(12'd2); push(12'd3);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_early_valid: got %0b want 0", out_valid);
      end
      push(12'd4);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd10 || out_max !== 12'd4) begin
         failures++;
         $display("FAIL basic_result: got valid=%0b sum=%0d max=%0d, want 1/10/4", out_valid, out_sum, out_max);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL basic_hold_ready: got %0b want 0", in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_drain: got valid=%0b in_ready=%0b, want 0/1", out_valid, in_ready);
      end
      $display("basic: sum=%0d max=%0d", out_sum, out_max);
   endtask

   task automatic test_full_scale();
      out_ready = 1'b1;
      push(12'hFFF); push(12'hFFF); push(12'hFFF); push(12'hFFF);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'h3FFC || out_max !== 12'hFFF) begin
         failures++;
         $display("FAIL full_scale: got valid=%0b sum=%h max=%h, want 1/3ffc/fff", out_valid, out_sum, out_max);
      end
      $display("full_scale: sum=%h max=%h", out_sum, out_max);
      tick();
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0;
      push(12'd5); push(12'd9); push(12'd2); push(12'd7);
      in_valid = 1'b1;
      in_data  = 12'd100;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 16'd23 || out_max !== 12'd9 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold_%0d: got valid=%0b sum=%0d max=%0d in_ready=%0b, want 1/23/9/0", i, out_valid, out_sum, out_max, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release: got valid=%0b want 0", out_valid);
      end
      push(12'd1); push(12'd1); push(12'd1); push(12'd1);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd4 || out_max !== 12'd1) begin
         failures++;
         $display("FAIL bp_next_block: got valid=%0b sum=%0d max=%0d, want 1/4/1", out_valid, out_sum, out_max);
      end
      $display("back_pressure: next sum=%0d", out_sum);
      tick();
   endtask

   task automatic test_enable_gap();
      out_ready = 1'b1;
      push(12'd3); push(12'd8);
      en       = 1'b0;
      in_valid = 1'b1;
      in_data  = 12'hAAA;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL en_gap_%0d: got in_ready=%0b valid=%0b, want 0/0", i, in_ready, out_valid);
         end
         tick();
      end
      en = 1'b1;
      push(12'd1); push(12'd2);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd14 || out_max !== 12'd8) begin
         failures++;
         $display("FAIL en_result: got valid=%0b sum=%0d max=%0d, want 1/14/8", out_valid, out_sum, out_max);
      end
      $display("enable_gap: sum=%0d max=%0d", out_sum, out_max);
      tick();
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      push(12'd6); push(12'd7);
      in_valid = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_partial: got valid=%0b want 0", out_valid);
      end
      push(12'd9); push(12'd9); push(12'd9); push(12'd9);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd36 || out_max !== 12'd9) begin
         failures++;
         $display("FAIL midrst_block: got valid=%0b sum=%0d max=%0d, want 1/36/9", out_valid, out_sum, out_max);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 16'd0 || out_max !== 12'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_hold: got valid=%0b sum=%0d max=%0d in_ready=%0b, want 0/0/0/1", out_valid, out_sum, out_max, in_ready);
      end
      out_ready = 1'b1;
      push(12'd4); push(12'd4); push(12'd4); push(12'd4);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd16 || out_max !== 12'd4) begin
         failures++;
         $display("FAIL midrst_after: got valid=%0b sum=%0d max=%0d, want 1/16/4", out_valid, out_sum, out_max);
      end
      $display("mid_reset: sum=%0d", out_sum);
      tick();
   endtask

   task automatic test_all_zero();
      out_ready = 1'b0;
      push(12'd0); push(12'd0); push(12'd0); push(12'd0);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd0 || out_max !== 12'd0) begin
         failures++;
         $display("FAIL zero_block: got valid=%0b sum=%0d max=%0d, want 1/0/0", out_valid, out_sum, out_max);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL zero_drain: got valid=%0b in_ready=%0b, want 0/1", out_valid, in_ready);
      end
      $display("all_zero: sum=%0d max=%0d", out_sum, out_max);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_full_scale();
      test_back_pressure();
      test_enable_gap();
      test_mid_reset();
      test_all_zero();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
